hazard_pipe_regs: RTL
=====================

# hazard_pipe_regs

Pipeline-register block for the 5-stage SCPU datapath holding the PC, IF/ID and ID/EX registers. It consumes the stall/bubble controls from the load-use hazard unit (pc_write, ifid_write, idex_zero) and the branch flush from EX, and applies them cycle by cycle. Its ID/EX outputs feed the EX stage and feed back to the hazard unit as the EX-stage rd address and instruction. Two saturating performance counters report stall and bubble cycles.

## Interface
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP, 32'h0000_0013 (addi x0,x0,0), instruction used as a bubble.
- CTRL_W, 16, width of the decoded control bundle.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_write  in  1  1 = PC may advance.
- ifid_write  in  1  1 = IF/ID may load.
- idex_zero  in  1  1 = load a bubble into ID/EX.
- flush  in  1  branch/jump taken in EX.
- flush_target  in  XLEN  redirect PC.
- if_inst  in  32  instruction fetched at pc.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  decoded ID-stage operands.
- id_rd_addr  in  5  ID-stage destination register.
- id_ctrl  in  CTRL_W  ID-stage control bundle.
- pc  out  XLEN  fetch address.
- ifid_pc  out  XLEN; ifid_inst  out  32; ifid_valid  out  1.
- idex_pc, idex_rs1_data, idex_rs2_data, idex_imm  out  XLEN.
- idex_inst  out  32; idex_rd_addr  out  5; idex_ctrl  out  CTRL_W; idex_valid  out  1.
- stall_cnt, bubble_cnt  out  CNT_W  saturating event counters.

## Operation
- Priority per edge: rst > flush > stall controls > normal advance.
- PC: flush → flush_target. Else pc_write=1 → pc+4, modulo 2^XLEN (wraps). Else hold.
- IF/ID: flush → ifid_inst=NOP, ifid_pc=0, ifid_valid=0. Else ifid_write=1 → capture if_inst, pc and valid=1. Else hold all fields.
- ID/EX: flush or idex_zero → bubble: inst=NOP, ctrl=0, rd=0, pc/data/imm=0, valid=0. Otherwise capture ifid_pc, ifid_inst, ifid_valid, id_* inputs.
- Enables are applied independently. pc_write=0 with ifid_write=1 is legal: IF/ID reloads the same pc and instruction.
- stall_cnt increments when pc_write=0 and flush=0.
- bubble_cnt increments when idex_zero=1 and flush=0.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- Bubble NOP has opcode 0010011, not a load. A single load-use hazard therefore produces exactly one stall cycle.

## Timing
- Reset values: pc=RESET_PC; ifid_inst=idex_inst=NOP; all other register outputs 0; valids 0; counters 0.
- Latency: every output is registered, with one cycle from input to output. There are no combinational paths from inputs to outputs.
- Cycle after rst deasserts: IF/ID captures the instruction at RESET_PC and pc becomes RESET_PC+4.
- Load-use hazard, cycle t: the load is in EX and controls are (0,0,1).
  - At t+1: pc and IF/ID are unchanged; ID/EX holds a bubble; the load has moved on.
  - At t+1 the hazard unit sees NOP in EX and deasserts, so the dependent instruction enters ID/EX at t+2.
- flush together with idex_zero: the flush result applies (PC to target, both stages cleared); neither counter increments.
- rst asserted mid-stall or mid-flush: all state returns to reset values on that edge, and pending controls are discarded.

## Structure
- Package pipe_pkg holds NOP, RESET_PC, CTRL_W, a packed idex_t struct (pc, inst, rs1/rs2 data, imm, rd, ctrl, valid) and an ifid_t struct.
- Sub-module pipe_reg: generic register with parameterised width and clear value, plus synchronous rst, clr and en inputs (priority rst > clr > en). It is instantiated for PC (no clr), IF/ID and ID/EX.
- Counters are inline, one always block each.

## Test plan
- Reset: hold rst 3 cycles, release. Required: pc=0, then pc=4, 8 on following edges; ifid_valid=1 after the first edge; counters 0.
- Straight line: 4 instructions, controls (1,1,0). Required: each instruction appears in ID/EX two cycles after its fetch, with idex_valid=1.
- Load-use: drive (0,0,1) for one cycle with pc=0x10. Required: pc stays 0x10; ifid is held; idex_inst=0x00000013 and idex_valid=0; stall_cnt=1, bubble_cnt=1; the next cycle resumes normally.
- Flush: flush=1, target 0x200, during a stall cycle. Required: pc=0x200; ifid_inst=NOP and ifid_valid=0; ID/EX holds a bubble; counters unchanged.
- Wrap: set pc to 0xFFFFFFFC via flush, then advance. Required: pc=0x00000000.
- Saturation: CNT_W=4, hold pc_write=0 for 20 cycles. Required: stall_cnt stops at 15; rst returns it to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the SCPU pipeline-register block.
//   ifid_t  : IF/ID register contents (pc, inst, valid)
//   idex_t  : ID/EX register contents (pc, inst, operands, imm, rd, ctrl, valid)
//   ifid_bubble / idex_bubble : the cleared contents loaded on reset, flush or bubble
package pipe_pkg;

  localparam int          XLEN     = 32;
  localparam int          CTRL_W   = 16;
  localparam int          CNT_W    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  // addi x0,x0,0 -- opcode 0010011, so a bubble never looks like a load.
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            valid;
  } ifid_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } idex_t;

  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b       = '0;
    b.inst  = nop;
    return b;
  endfunction

  function automatic idex_t idex_bubble(input logic [31:0] nop);
    idex_t b;
    b      = '0;
    b.inst = nop;
    return b;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous reset, clear and load enable.
// Priority per edge: rst > clr > en; with none asserted the register holds.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, loads RST_VAL
//   clr     : synchronous clear, loads CLR_VAL
//   en      : load enable, captures d
//   d / q   : data in / registered data out (W bits)
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_pipe_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage SCPU datapath.
// Applies load-use stall/bubble controls and the EX branch flush each cycle,
// and counts stall and bubble cycles in saturating counters.
//   clk, rst                       : clock, synchronous active-high reset
//   pc_write, ifid_write, idex_zero: hazard-unit stall/bubble controls
//   flush, flush_target            : taken branch/jump from EX and its target
//   if_inst                        : instruction fetched at pc
//   id_rs1_data, id_rs2_data, id_imm, id_rd_addr, id_ctrl : ID-stage decode
//   pc                             : fetch address
//   ifid_*                         : IF/ID register outputs
//   idex_*                         : ID/EX register outputs (to EX and hazard unit)
//   stall_cnt, bubble_cnt          : saturating event counters
module hazard_pipe_regs #(
  parameter int              XLEN     = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter logic [31:0]     NOP      = pipe_pkg::NOP,
  parameter int              CTRL_W   = pipe_pkg::CTRL_W,
  parameter int              CNT_W    = pipe_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              ifid_write,
  input  logic              idex_zero,
  input  logic              flush,
  input  logic [XLEN-1:0]   flush_target,
  input  logic [31:0]       if_inst,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rd_addr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   ifid_pc,
  output logic [31:0]       ifid_inst,
  output logic              ifid_valid,
  output logic [XLEN-1:0]   idex_pc,
  output logic [XLEN-1:0]   idex_rs1_data,
  output logic [XLEN-1:0]   idex_rs2_data,
  output logic [XLEN-1:0]   idex_imm,
  output logic [31:0]       idex_inst,
  output logic [4:0]        idex_rd_addr,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic              idex_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  import pipe_pkg::ifid_t;
  import pipe_pkg::idex_t;
  import pipe_pkg::ifid_bubble;
  import pipe_pkg::idex_bubble;

  localparam ifid_t IFID_CLR = ifid_bubble(NOP);
  localparam idex_t IDEX_CLR = idex_bubble(NOP);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---- PC (stage p0) ----
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] pc_next_p0;
  logic            pc_en_p0;

  // A flush overrides a stall, so it must also enable the PC load.
  assign pc_en_p0   = flush | pc_write;
  assign pc_next_p0 = flush ? flush_target : pc_p0 + XLEN'(4);

  pipe_reg #(
    .W       (XLEN),
    .RST_VAL (RESET_PC),
    .CLR_VAL ('0)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (pc_en_p0),
    .d   (pc_next_p0),
    .q   (pc_p0)
  );

  // ---- IF/ID (stage p1) ----
  ifid_t ifid_d_p1;
  ifid_t ifid_p1;

  always_comb begin
    ifid_d_p1       = '0;
    ifid_d_p1.pc    = pc_p0;
    ifid_d_p1.inst  = if_inst;
    ifid_d_p1.valid = 1'b1;
  end

  pipe_reg #(
    .W       ($bits(ifid_t)),
    .RST_VAL (IFID_CLR),
    .CLR_VAL (IFID_CLR)
  ) u_ifid (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (ifid_write),
    .d   (ifid_d_p1),
    .q   (ifid_p1)
  );

  // ---- ID/EX (stage p2) ----
  idex_t idex_d_p2;
  idex_t idex_p2;

  always_comb begin
    idex_d_p2          = '0;
    idex_d_p2.pc       = ifid_p1.pc;
    idex_d_p2.inst     = ifid_p1.inst;
    idex_d_p2.rs1_data = id_rs1_data;
    idex_d_p2.rs2_data = id_rs2_data;
    idex_d_p2.imm      = id_imm;
    idex_d_p2.rd       = id_rd_addr;
    idex_d_p2.ctrl     = id_ctrl;
    idex_d_p2.valid    = ifid_p1.valid;
  end

  // ID/EX never holds: it either advances or takes a bubble.
  pipe_reg #(
    .W       ($bits(idex_t)),
    .RST_VAL (IDEX_CLR),
    .CLR_VAL (IDEX_CLR)
  ) u_idex (
    .clk (clk),
    .rst (rst),
    .clr (flush | idex_zero),
    .en  (1'b1),
    .d   (idex_d_p2),
    .q   (idex_p2)
  );

  // ---- performance counters ----
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Cycles swallowed by a flush are branch penalties, not hazard stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_write && !flush) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (idex_zero && !flush) begin
      bubble_q <= sat_inc(bubble_q);
    end
  end

  assign pc            = pc_p0;
  assign ifid_pc       = ifid_p1.pc;
  assign ifid_inst     = ifid_p1.inst;
  assign ifid_valid    = ifid_p1.valid;
  assign idex_pc       = idex_p2.pc;
  assign idex_inst     = idex_p2.inst;
  assign idex_rs1_data = idex_p2.rs1_data;
  assign idex_rs2_data = idex_p2.rs2_data;
  assign idex_imm      = idex_p2.imm;
  assign idex_rd_addr  = idex_p2.rd;
  assign idex_ctrl     = idex_p2.ctrl;
  assign idex_valid    = idex_p2.valid;
  assign stall_cnt     = stall_q;
  assign bubble_cnt    = bubble_q;

endmodule
